// File: rtl/pcihellocore_avmm_cmd_master.sv
// Avalon-MM command master for the pcihellocore PIO slaves: turns one command
// into a write, a read, or a read-modify-write, then returns one response.
module pcihellocore_avmm_cmd_master #(
   parameter int ADDR_W      = 2,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_readdata,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_GAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [2:0]        state_reg;
   logic [1:0]        op_reg;
   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] old_reg;
   logic [3:0]        wait_reg;
   logic [ADDR_W-1:0] address_reg;
   logic              chipselect_reg;
   logic              write_n_reg;
   logic [DATA_W-1:0] writedata_reg;
   logic              rsp_valid_reg;
   logic [DATA_W-1:0] rsp_readdata_reg;

   assign cmd_ready      = (state_reg == S_IDLE);
   assign avm_address    = address_reg;
   assign avm_chipselect = chipselect_reg;
   assign avm_write_n    = write_n_reg;
   assign avm_writedata  = writedata_reg;
   assign rsp_valid      = rsp_valid_reg;
   assign rsp_readdata   = rsp_readdata_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Aborts any in-flight access; a half-done RMW never reaches its write.
         state_reg        <= S_IDLE;
         op_reg           <= '0;
         data_reg         <= '0;
         old_reg          <= '0;
         wait_reg         <= '0;
         address_reg      <= '0;
         chipselect_reg   <= 1'b0;
         write_n_reg      <= 1'b1;
         writedata_reg    <= '0;
         rsp_valid_reg    <= 1'b0;
         rsp_readdata_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_reg         <= cmd_op;
                  data_reg       <= cmd_data;
                  address_reg    <= cmd_address;
                  chipselect_reg <= 1'b1;
                  wait_reg       <= WAIT_INIT;
                  if (cmd_op == OP_WRITE) begin
                     write_n_reg   <= 1'b0;
                     writedata_reg <= cmd_data;
                     state_reg     <= S_WR;
                  end else begin
                     write_n_reg <= 1'b1;
                     state_reg   <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (wait_reg == 4'd0) begin
                  old_reg        <= avm_readdata;
                  chipselect_reg <= 1'b0;
                  if (op_reg == OP_READ) begin
                     rsp_valid_reg    <= 1'b1;
                     rsp_readdata_reg <= avm_readdata;
                     state_reg        <= S_RESP;
                  end else begin
                     state_reg <= S_GAP;
                  end
               end else begin
                  wait_reg <= wait_reg - 4'd1;
               end
            end
            S_GAP: begin
               writedata_reg  <= (op_reg == OP_SET) ? (old_reg | data_reg)
                                                    : (old_reg & ~data_reg);
               chipselect_reg <= 1'b1;
               write_n_reg    <= 1'b0;
               wait_reg       <= WAIT_INIT;
               state_reg      <= S_WR;
            end
            S_WR: begin
               if (wait_reg == 4'd0) begin
                  chipselect_reg   <= 1'b0;
                  write_n_reg      <= 1'b1;
                  rsp_valid_reg    <= 1'b1;
                  // A plain write reports zero; RMW reports the pre-modify value.
                  rsp_readdata_reg <= (op_reg == OP_WRITE) ? '0 : old_reg;
                  state_reg        <= S_RESP;
               end else begin
                  wait_reg <= wait_reg - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pcihellocore_avmm_cmd_master.md
Name: pcihellocore_avmm_cmd_master

Overview:
- Avalon-MM initiator that drives the PIO-style register slaves in pcihellocore, such as fan control and LED/display PIOs.
- Accepts single-word commands on a valid/ready interface and turns each into one bus access: write, read, or read-modify-write (set/clear bits).
- Uses the slave signal set: address, chipselect, write_n, writedata, readdata. Slaves have no waitrequest and zero read latency.
- Returns one response per command on a valid/ready interface.

Parameters:
ADDR_W, 2, width of avm_address and cmd_address
DATA_W, 32, data width of bus and command/response paths
WAIT_STATES, 0, extra cycles chipselect is held per access phase (0..15); access phase length = 1+WAIT_STATES

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00 write, 01 read, 10 RMW set (old|mask), 11 RMW clear (old&~mask)
cmd_address  in  ADDR_W  target register address
cmd_data  in  DATA_W  write data (op 00) or bit mask (ops 10/11); ignored for op 01
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_readdata  out  DATA_W  read value (op 01), pre-modify value (ops 10/11), 0 for op 00
avm_address  out  ADDR_W  bus address
avm_chipselect  out  1  bus select, active-high
avm_write_n  out  1  bus write strobe, active-low
avm_writedata  out  DATA_W  bus write data
avm_readdata  in  DATA_W  bus read data, valid combinationally while chipselect asserted

Behaviour:
- Single clock domain; reset is synchronous and active-high. All outputs are registered, except cmd_ready = (state==IDLE).
- Reset values: state IDLE; avm_chipselect 0; avm_write_n 1; avm_address 0; avm_writedata 0; rsp_valid 0; rsp_readdata 0. cmd_ready is 1 in the first cycle after reset deasserts.
- States: IDLE, RD (read phase), GAP, WR (write phase), RESP.
- Accept: cmd_valid && cmd_ready at edge of cycle n. Op, address, data and mask are latched into internal registers.
- Op 00: IDLE->WR.
  - Cycles n+1..n+1+WAIT_STATES: chipselect=1, write_n=0, address and writedata driven from the latched command.
  - Then RESP: rsp_valid=1 from cycle n+2+WAIT_STATES, rsp_readdata=0.
- Op 01: IDLE->RD.
  - Cycles n+1..n+1+WAIT_STATES: chipselect=1, write_n=1.
  - avm_readdata is captured at the edge ending the last RD cycle.
  - RESP from n+2+WAIT_STATES with the captured value.
- Ops 10/11: IDLE->RD->GAP->WR->RESP.
  - RD as for op 01.
  - GAP is exactly one cycle with chipselect=0, write_n=1. The new value (old|mask, or old&~mask) is computed in GAP.
  - WR is as for op 00, using the new value.
  - rsp_valid from n+4+2*WAIT_STATES; rsp_readdata = old value.
- Wait-state counter: 4 bits, loaded with WAIT_STATES on phase entry, decremented each cycle. The phase ends when the counter reads 0; no wrap.
- write_n is low only in WR. chipselect is low in IDLE, GAP and RESP. Address and writedata hold stable through each whole phase.
- RESP: rsp_valid and rsp_readdata hold stable until rsp_ready is high at a clock edge.
  - On that edge: rsp_valid->0 and the next state is IDLE. The next command can be accepted in the following cycle.
  - There is no command/response overlap: at most one command is in flight.
- Simultaneous events:
  - A new cmd_valid while busy is not accepted (cmd_ready=0); the command source holds it.
  - rsp_ready asserted outside RESP is ignored.
- Reset mid-operation: on the edge where reset is sampled high, the in-flight access is aborted. chipselect=0 and write_n=1 from the next cycle. No response is produced, and a partial RMW never issues its write.
- No error or timeout path: slaves always complete in a fixed time.

Test Plan:
- Reset release: check all outputs at reset values, cmd_ready=1. Then write op 00, addr 0, data 0x0000_00A5, WAIT_STATES=0 -> one cycle of chipselect=1/write_n=0 with addr 0 and data 0xA5; rsp_valid next cycle with readdata 0; slave model reg=0xA5.
- Read: slave reg=0x1234_5678, op 01 addr 0 -> one cycle of chipselect=1/write_n=1; rsp_readdata=0x1234_5678 two cycles after accept. Read of addr 1 (model returns 0) -> rsp_readdata=0.
- RMW set: reg=0x0000_00F0, op 10 mask 0x0000_000F -> RD, 1 GAP cycle with chipselect=0, then WR of 0xFF; rsp_readdata=0xF0; rsp_valid 4 cycles after accept. RMW clear with mask 0x30 on 0xFF -> written value 0xCF.
- WAIT_STATES=3 build: read op -> chipselect high for exactly 4 cycles; data captured on the 4th. RMW -> rsp_valid at n+10.
- Backpressure: rsp_ready=0 for 5 cycles with a second cmd_valid asserted -> rsp_valid and data stable; cmd_ready=0 throughout; second command accepted in the cycle after the rsp handshake.
- Reset asserted during the RD phase of an RMW -> next cycle chipselect=0, no WR phase, no rsp_valid; slave reg unchanged.
